hlsm_start_driver: RTL and testbench
====================================

// Module: hlsm_start_driver
// PURPOSE
//  Initiator side of the Start/Done HLSM handshake: accepts operand sets over a valid/ready
//  request port, drives Start plus stable operands into one HLSM instance, and waits for Done.
//  On Done it captures z/x and returns them over a valid/ready response port.
//  A timeout watchdog reports a hung HLSM. Sits between the stimulus/bus logic and the HLSM.
// PARAMETERS
//  DATA_W   32  width of each signed operand and result
//  TIMEOUT  64  cycles to wait for Done before an error response (>=4)
//  CNT_W    16  width of completed-transaction counter
// PORTS
//  Clk        in   1       clock, all state on posedge
//  Rst        in   1       asynchronous, active-low reset
//  req_valid  in   1       operand set offered
//  req_ready  out  1       driver can accept operands (high only in IDLE)
//  req_a/b/c  in   DATA_W  signed operands
//  Start      out  1       one-cycle start pulse to HLSM
//  Done       in   1       HLSM completion pulse
//  hl_a/b/c   out  DATA_W  registered operands to HLSM
//  hl_z/hl_x  in   DATA_W  HLSM results, valid when Done=1
//  rsp_valid  out  1       response available
//  rsp_ready  in   1       consumer takes response
//  rsp_z/x    out  DATA_W  captured results (0 on error)
//  rsp_err    out  1       1 = timeout, results invalid
//  busy       out  1       state != IDLE
//  txn_count  out  CNT_W   completed responses, saturates at all-ones
// BEHAVIOUR
//  - Reset (Rst=0, async): state=IDLE; Start, rsp_valid, rsp_err, busy=0; hl_*, rsp_z/x,
//    txn_count, timer=0. Reset mid-transaction drops Start immediately and discards results.
//  - States: IDLE, WAIT, RESP, RECOVER.
//  - IDLE: req_ready=1. On req_valid&req_ready at edge N: latch req_a/b/c into hl_a/b/c,
//    Start<=1, timer<=0, go to WAIT.
//  - WAIT: Start high for exactly the first WAIT cycle (N+1), then 0. Timer increments each
//    cycle. Done sampled while Start=1 is ignored (stale). Done=1 later: capture hl_z/hl_x,
//    rsp_err<=0, rsp_valid<=1, go to RESP. If timer==TIMEOUT-1 with no Done: rsp_z/x<=0,
//    rsp_err<=1, rsp_valid<=1, go to RESP. Done and timeout in the same cycle: Done wins.
//  - Latency: rsp_valid rises the cycle after Done is sampled.
//  - RESP: rsp_valid and rsp_* hold stable until rsp_ready=1. On handshake: rsp_valid<=0,
//    txn_count+=1 (saturating). Next state is IDLE if rsp_err=0, else RECOVER.
//  - RECOVER: req_ready=0, Start=0, timer restarted. Exit to IDLE on a late Done (results
//    discarded) or after TIMEOUT cycles, whichever is first.
//  - hl_a/b/c change only on an IDLE accept, so they stay stable from Start until IDLE.
//  - Done while in IDLE or RESP is ignored. Done is never queued.
//  - Widths: results are passed through unmodified. Timer is clog2(TIMEOUT) bits and never
//    wraps because the timeout fires first.
// STRUCTURE
//  - Package hlsm_drv_pkg: state enum (IDLE=0, WAIT=1, RESP=2, RECOVER=3), DATA_W default,
//    TIMER_W function.
//  - One sub-module: hlsm_timeout_ctr (clear, enable, terminal-count pulse at TIMEOUT-1).
//    It is reused for the WAIT and RECOVER timing.
//  - Top level holds the FSM, the operand/result registers and the counter.
// TESTING
//  The bench models the HLSM with programmable latency L, returning z=a+b and x=a-c.
//  1. Nominal: a=5,b=3,c=1, L=6, rsp_ready=1
//     -> Start pulses 1 cycle; rsp_z=8, rsp_x=4, rsp_err=0; txn_count=1.
//  2. Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid
//     -> rsp_* stay stable, req_ready=0 throughout; count increments only on the handshake.
//  3. Timeout: model never sends Done, TIMEOUT=64
//     -> rsp_valid with rsp_err=1 and z=x=0 at 64 cycles after Start; after the handshake
//        the driver sits in RECOVER for 64 cycles, then req_ready=1.
//  4. Late Done in RECOVER: Done 5 cycles after the error handshake
//     -> IDLE on the next cycle; no extra response; txn_count unchanged.
//  5. Reset mid-WAIT: Rst=0 three cycles after Start
//     -> all outputs 0 immediately; a later Done produces no response.
//  6. Stale/edge Done: Done high in the Start cycle, then real Done at L=3; also Done in the
//     same cycle as the timeout -> first Done ignored; rsp_err=0 with correct results.

Source files
------------

// File: rtl/hlsm_drv_pkg.sv
// hlsm_drv_pkg: shared state encoding, default widths and timer sizing for the HLSM start driver
package hlsm_drv_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    // Timer only ever counts 0..timeout-1, so clog2 bits are enough
    function automatic int TIMER_W(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/hlsm_timeout_ctr.sv
// hlsm_timeout_ctr: clearable cycle counter with a terminal-count pulse at TIMEOUT-1
module hlsm_timeout_ctr
    import hlsm_drv_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int W = TIMER_W(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    // Count enabled cycles; hold at the terminal value so the count never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/hlsm_start_driver.sv
// hlsm_start_driver: Start/Done initiator that feeds one HLSM and returns its results with a timeout watchdog
module hlsm_start_driver
    import hlsm_drv_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic signed [DATA_W-1:0] req_a,
    input  logic signed [DATA_W-1:0] req_b,
    input  logic signed [DATA_W-1:0] req_c,
    output logic                     Start,
    input  logic                     Done,
    output logic signed [DATA_W-1:0] hl_a,
    output logic signed [DATA_W-1:0] hl_b,
    output logic signed [DATA_W-1:0] hl_c,
    input  logic signed [DATA_W-1:0] hl_z,
    input  logic signed [DATA_W-1:0] hl_x,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic signed [DATA_W-1:0] rsp_z,
    output logic signed [DATA_W-1:0] rsp_x,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [CNT_W-1:0]         txn_count
);

    logic [1:0] state;
    logic       accept;
    logic       rsp_hs;
    logic       done_ok;
    logic       tc;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = (state == ST_RESP) && rsp_ready;
    // A Done seen while Start is still high belongs to a previous operation
    assign done_ok   = (state == ST_WAIT) && Done && !Start;

    hlsm_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (Clk),
        .rst_n (Rst),
        .clear (accept || rsp_hs),
        .en    ((state == ST_WAIT) || (state == ST_RECOVER)),
        .tc    (tc)
    );

    // Handshake FSM with operand, result and transaction-count registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= ST_IDLE;
            Start     <= 1'b0;
            hl_a      <= '0;
            hl_b      <= '0;
            hl_c      <= '0;
            rsp_valid <= 1'b0;
            rsp_z     <= '0;
            rsp_x     <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            Start <= accept;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hl_a  <= req_a;
                        hl_b  <= req_b;
                        hl_c  <= req_c;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (done_ok) begin
                        rsp_z     <= hl_z;
                        rsp_x     <= hl_x;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (tc) begin
                        rsp_z     <= '0;
                        rsp_x     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= (&txn_count) ? txn_count : txn_count + CNT_W'(1);
                        state     <= rsp_err ? ST_RECOVER : ST_IDLE;
                    end
                end
                default: begin
                    if (Done || tc)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hlsm_start_driver.sv
// tb_hlsm_start_driver: scoreboard bench for the HLSM start driver with a hand-driven HLSM model
module tb_hlsm_start_driver;

    localparam int DW = 32;
    localparam int TO = 64;
    localparam int CW = 16;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic signed [DW-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic                 Start;
    logic                 Done = 1'b0;
    logic signed [DW-1:0] hl_a, hl_b, hl_c;
    logic signed [DW-1:0] hl_z = '0, hl_x = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic signed [DW-1:0] rsp_z, rsp_x;
    logic                 rsp_err;
    logic                 busy;
    logic [CW-1:0]        txn_count;

    typedef struct {
        logic [DW-1:0] z;
        logic [DW-1:0] x;
        logic          err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 Clk = ~Clk;

    hlsm_start_driver #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .Start     (Start),
        .Done      (Done),
        .hl_a      (hl_a),
        .hl_b      (hl_b),
        .hl_c      (hl_c),
        .hl_z      (hl_z),
        .hl_x      (hl_x),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_x     (rsp_x),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .txn_count (txn_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] z, input logic [DW-1:0] x, input logic err);
        rsp_t e;
        e.z = z;
        e.x = x;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Offer one operand set from IDLE; returns in the Start cycle
    task automatic accept(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                          input logic signed [DW-1:0] c);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_c = c;
        cyc();
        req_valid = 1'b0;
        chk("start_pulse", {31'd0, Start}, 32'd1);
        chk("hl_a", hl_a, a);
        chk("hl_b", hl_b, b);
        chk("hl_c", hl_c, c);
    endtask

    // HLSM model: one-cycle Done with results on hl_z/hl_x
    task automatic pulse_done(input logic signed [DW-1:0] z, input logic signed [DW-1:0] x);
        Done = 1'b1;
        hl_z = z;
        hl_x = x;
        cyc();
        Done = 1'b0;
        hl_z = '0;
        hl_x = '0;
    endtask

    // From the Start cycle, answer with Done in cycle Start+lat and check rsp_valid rises next
    task automatic wait_done(input int lat, input logic signed [DW-1:0] z, input logic signed [DW-1:0] x);
        cyc();
        chk("start_drops", {31'd0, Start}, 32'd0);
        repeat (lat - 1) cyc();
        pulse_done(z, x);
        chk("rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_err_ok", {31'd0, rsp_err}, 32'd0);
    endtask

    // Monitor: every response handshake must match the head of the scoreboard
    always @(negedge Clk) begin
        rsp_t e;
        if (Rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: got z=%0d x=%0d err=%0b, expected no response", rsp_z, rsp_x, rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_z", rsp_z, e.z);
                chk("rsp_x", rsp_x, e.x);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_start", {31'd0, Start}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_txn", {16'd0, txn_count}, 32'd0);
        chk("rst_hl_a", hl_a, 32'd0);
        chk("rst_rsp_z", rsp_z, 32'd0);
        cyc();
        Rst = 1'b1;
        cyc();

        // Nominal
        accept(5, 3, 1);
        push(8, 4, 1'b0);
        wait_done(6, 5 + 3, 5 - 1);
        cyc();
        chk("t1_txn", {16'd0, txn_count}, 32'd1);
        chk("t1_valid_low", {31'd0, rsp_valid}, 32'd0);
        chk("t1_req_ready", {31'd0, req_ready}, 32'd1);

        // Back-pressure
        rsp_ready = 1'b0;
        accept(10, 20, 3);
        push(30, 7, 1'b0);
        wait_done(2, 30, 7);
        for (int i = 0; i < 10; i++) begin
            chk("t2_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("t2_z_hold", rsp_z, 32'd30);
            chk("t2_x_hold", rsp_x, 32'd7);
            chk("t2_req_ready", {31'd0, req_ready}, 32'd0);
            chk("t2_txn_hold", {16'd0, txn_count}, 32'd1);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        chk("t2_txn", {16'd0, txn_count}, 32'd2);
        chk("t2_valid_low", {31'd0, rsp_valid}, 32'd0);

        // Timeout, then full RECOVER interval
        accept(1, 2, 3);
        push(0, 0, 1'b1);
        repeat (TO - 1) cyc();
        chk("t3_no_valid_early", {31'd0, rsp_valid}, 32'd0);
        cyc();
        chk("t3_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t3_err", {31'd0, rsp_err}, 32'd1);
        repeat (TO) cyc();
        chk("t3_recover_ready", {31'd0, req_ready}, 32'd0);
        chk("t3_recover_busy", {31'd0, busy}, 32'd1);
        cyc();
        chk("t3_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("t3_txn", {16'd0, txn_count}, 32'd3);

        // Late Done in RECOVER
        accept(4, 4, 4);
        push(0, 0, 1'b1);
        repeat (TO) cyc();
        chk("t4_valid", {31'd0, rsp_valid}, 32'd1);
        repeat (5) cyc();
        chk("t4_still_recover", {31'd0, req_ready}, 32'd0);
        pulse_done(32'sd99, 32'sd98);
        chk("t4_idle", {31'd0, req_ready}, 32'd1);
        chk("t4_no_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (3) cyc();
        chk("t4_txn", {16'd0, txn_count}, 32'd4);

        // Reset mid-WAIT
        accept(7, 7, 7);
        repeat (3) cyc();
        Rst = 1'b0;
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_hl_a", hl_a, 32'd0);
        chk("t5_txn", {16'd0, txn_count}, 32'd0);
        chk("t5_valid", {31'd0, rsp_valid}, 32'd0);
        cyc();
        Rst = 1'b1;
        pulse_done(32'sd14, 32'sd0);
        repeat (3) cyc();
        chk("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("t5_ready", {31'd0, req_ready}, 32'd1);

        // Reset in the Start cycle drops Start at once
        accept(1, 1, 1);
        Rst = 1'b0;
        #1;
        chk("t5_start_drop", {31'd0, Start}, 32'd0);
        cyc();
        Rst = 1'b1;
        cyc();

        // Stale Done in the Start cycle, real Done at L=3
        accept(100, -50, 25);
        Done = 1'b1;
        hl_z = 32'sd111;
        hl_x = 32'sd222;
        cyc();
        Done = 1'b0;
        chk("t6_stale_ignored", {31'd0, rsp_valid}, 32'd0);
        repeat (2) cyc();
        push(50, 75, 1'b0);
        pulse_done(32'sd50, 32'sd75);
        chk("t6_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t6_err", {31'd0, rsp_err}, 32'd0);
        cyc();
        chk("t6_txn", {16'd0, txn_count}, 32'd1);

        // Done in the same cycle as the timeout
        accept(9, 4, 2);
        push(13, 7, 1'b0);
        repeat (TO - 1) cyc();
        pulse_done(32'sd13, 32'sd7);
        chk("t6b_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t6b_err", {31'd0, rsp_err}, 32'd0);
        cyc();
        chk("t6b_idle", {31'd0, req_ready}, 32'd1);
        chk("t6b_txn", {16'd0, txn_count}, 32'd2);

        repeat (3) cyc();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
